// File: rtl/usr_pkg.sv
// Mode codes, FSM encoding and mode classification for univ_shift_reg.
// USR_ARITH_SHIFT_EN adds mode 6 (ASR) to the set of multi-step modes.
package usr_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_RSVD = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // True for modes that run the counted single-bit step sequence.
  function automatic logic is_step_mode(input logic [MODE_W-1:0] mode);
    logic r;
    r = 1'b0;
    case (mode)
      MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL: r = 1'b1;
`ifdef USR_ARITH_SHIFT_EN
      MODE_ASR: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/usr_step.sv
// Single-bit step of the shift register: pure combinational next-q for one mode.
// Non-step modes pass q through; ASR only exists when USR_ARITH_SHIFT_EN is defined.
import usr_pkg::*;

module usr_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0]     i_q,
  input  logic [MODE_W-1:0] i_mode,
  input  logic              i_ser_in_r,
  input  logic              i_ser_in_l,
  output logic [DW-1:0]     o_q
);

  always_comb begin
    o_q = i_q;
    case (i_mode)
      MODE_SHR: o_q = {i_ser_in_r, i_q[DW-1:1]};
      MODE_SHL: o_q = {i_q[DW-2:0], i_ser_in_l};
      MODE_ROR: o_q = {i_q[0], i_q[DW-1:1]};
      MODE_ROL: o_q = {i_q[DW-2:0], i_q[DW-1]};
`ifdef USR_ARITH_SHIFT_EN
      MODE_ASR: o_q = {i_q[DW-1], i_q[DW-1:1]};
`endif
      default:  o_q = i_q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: LOAD/HOLD finish in one cycle, shift/rotate by N takes N RUN cycles then a done pulse.
// cmd_ready is low while busy; USR_ARITH_SHIFT_EN enables mode 6 (ASR), otherwise mode 6 acts as HOLD.
import usr_pkg::*;

module univ_shift_reg #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic              sync_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MODE_W-1:0] cmd_mode,
  input  logic [CW-1:0]     cmd_cnt,
  input  logic [DW-1:0]     load_data,
  input  logic              ser_in_r,
  input  logic              ser_in_l,
  output logic [DW-1:0]     q,
  output logic              ser_out_r,
  output logic              ser_out_l,
  output logic              busy,
  output logic              done
);

  state_t              r_state;
  logic [MODE_W-1:0]   r_mode;
  logic [CW-1:0]       r_cnt;
  logic [DW-1:0]       r_q;
  logic                r_done;

  logic                w_accept;
  logic [DW-1:0]       w_step_q;

  usr_step #(
    .DW (DW)
  ) u_step (
    .i_q        (r_q),
    .i_mode     (r_mode),
    .i_ser_in_r (ser_in_r),
    .i_ser_in_l (ser_in_l),
    .o_q        (w_step_q)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RUN);
  assign w_accept  = cmd_valid && cmd_ready;

  assign q         = r_q;
  assign ser_out_r = r_q[0];
  assign ser_out_l = r_q[DW-1];
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HOLD;
      r_cnt   <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (cmd_mode == MODE_LOAD) begin
              r_q    <= load_data;
              r_done <= 1'b1;
            end else if (is_step_mode(cmd_mode) && (cmd_cnt != '0)) begin
              // q is left alone here; the first step lands on the next edge.
              r_mode  <= cmd_mode;
              r_cnt   <= cmd_cnt;
              r_state <= ST_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_q   <= w_step_q;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: stimulus queues expected busy/done cycles, a monitor pops on each.
module tb_univ_shift_reg;
  import usr_pkg::*;

  localparam int DW = 8;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              sync_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [MODE_W-1:0] cmd_mode = MODE_HOLD;
  logic [CW-1:0]     cmd_cnt = '0;
  logic [DW-1:0]     load_data = '0;
  logic              ser_in_r = 1'b0;
  logic              ser_in_l = 1'b0;
  logic [DW-1:0]     q;
  logic              ser_out_r;
  logic              ser_out_l;
  logic              busy;
  logic              done;

  univ_shift_reg #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_cnt   (cmd_cnt),
    .load_data (load_data),
    .ser_in_r  (ser_in_r),
    .ser_in_l  (ser_in_l),
    .q         (q),
    .ser_out_r (ser_out_r),
    .ser_out_l (ser_out_l),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] q;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

`ifdef USR_ARITH_SHIFT_EN
  localparam logic [DW-1:0] Q_AFTER_M6 = 8'hE4;
`else
  localparam logic [DW-1:0] Q_AFTER_M6 = 8'h90;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_out(input logic [DW-1:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    exp_q.push_back(e);
  endtask

  // Expected cycles for a counted run: N busy cycles then a done cycle.
  task automatic expect_run(input logic [DW-1:0] seq[$]);
    for (int i = 0; i < seq.size() - 1; i++) expect_out(seq[i], 1'b1, 1'b0);
    expect_out(seq[seq.size()-1], 1'b0, 1'b1);
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("ready_timeout", 32'(k), 32'd0);
  endtask

  task automatic issue(input logic [MODE_W-1:0] m, input logic [CW-1:0] n, input logic [DW-1:0] d);
    wait_ready();
    cmd_mode  = m;
    cmd_cnt   = n;
    load_data = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Monitor: every busy or done cycle must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (busy === 1'b1 || done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output{busy,done}", 32'({busy, done}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("q",         32'(q),         32'(mon_e.q));
          check("busy",      32'(busy),      32'(mon_e.busy));
          check("done",      32'(done),      32'(mon_e.done));
          check("cmd_ready", 32'(cmd_ready), 32'(!mon_e.busy));
          check("ser_out_r", 32'(ser_out_r), 32'(mon_e.q[0]));
          check("ser_out_l", 32'(ser_out_l), 32'(mon_e.q[DW-1]));
        end
      end
    end
  end

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1 sync_rst = 1'b0;
    @(negedge clk);
    check("rst_q",     32'(q),         32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // LOAD: q updates on the accept edge, done one cycle later, never busy
    expect_out(8'hA5, 1'b0, 1'b1);
    issue(MODE_LOAD, 4'd0, 8'hA5);
    check("load_on_accept_edge", 32'(q), 32'hA5);

    // SHR x3 with ser_in_r=1
    ser_in_r = 1'b1;
    expect_run('{8'hA5, 8'hD2, 8'hE9, 8'hF4});
    issue(MODE_SHR, 4'd3, 8'h00);

    // ROL x9 wraps past DW, ROL x8 is identity
    expect_out(8'h81, 1'b0, 1'b1);
    issue(MODE_LOAD, 4'd0, 8'h81);
    expect_run('{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03});
    issue(MODE_ROL, 4'd9, 8'h00);
    expect_out(8'h81, 1'b0, 1'b1);
    issue(MODE_LOAD, 4'd0, 8'h81);
    expect_run('{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81});
    issue(MODE_ROL, 4'd8, 8'h00);

    // SHL x5 with a second command held valid; its fields change while busy
    ser_in_l = 1'b1;
    expect_run('{8'h81, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F});
    expect_out(8'h5A, 1'b0, 1'b1);
    wait_ready();
    cmd_mode  = MODE_SHL;
    cmd_cnt   = 4'd5;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_mode  = MODE_LOAD;
    cmd_cnt   = 4'd0;
    load_data = 8'hEE;
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("shl_done_timeout", 32'(k), 32'd0);
    load_data = 8'h5A;
    @(posedge clk);
    #1 cmd_valid = 1'b0;

    // Reset on the second step edge of SHR x4: no late done
    ser_in_r = 1'b0;
    expect_out(8'h5A, 1'b1, 1'b0);
    expect_out(8'h2D, 1'b1, 1'b0);
    issue(MODE_SHR, 4'd4, 8'h00);
    @(posedge clk);
    #1 sync_rst = 1'b1;
    @(posedge clk);
    #1 sync_rst = 1'b0;
    @(negedge clk);
    check("midrun_rst_q",     32'(q),         32'd0);
    check("midrun_rst_busy",  32'(busy),      32'd0);
    check("midrun_rst_done",  32'(done),      32'd0);
    check("midrun_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("queue_after_midrun_rst", 32'(exp_q.size()), 32'd0);

    // Mode 6: ASR when enabled, HOLD otherwise
    expect_out(8'h90, 1'b0, 1'b1);
    issue(MODE_LOAD, 4'd0, 8'h90);
`ifdef USR_ARITH_SHIFT_EN
    expect_run('{8'h90, 8'hC8, 8'hE4});
`else
    expect_out(8'h90, 1'b0, 1'b1);
`endif
    issue(MODE_ASR, 4'd2, 8'h00);

    // cnt==0 shift and reserved mode: immediate done, q unchanged
    expect_out(Q_AFTER_M6, 1'b0, 1'b1);
    issue(MODE_SHR, 4'd0, 8'h00);
    expect_out(Q_AFTER_M6, 1'b0, 1'b1);
    issue(MODE_RSVD, 4'd3, 8'h00);

    // Reset wins over a same-edge accept
    wait_ready();
    cmd_mode  = MODE_LOAD;
    load_data = 8'hFF;
    cmd_valid = 1'b1;
    sync_rst  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    sync_rst  = 1'b0;
    @(negedge clk);
    check("rst_vs_accept_q",    32'(q),    32'd0);
    check("rst_vs_accept_done", 32'(done), 32'd0);

    // ROR by DW restores the original value
    expect_out(8'h3C, 1'b0, 1'b1);
    issue(MODE_LOAD, 4'd0, 8'h3C);
    expect_run('{8'h3C, 8'h1E, 8'h0F, 8'h87, 8'hC3, 8'hE1, 8'hF0, 8'h78, 8'h3C});
    issue(MODE_ROR, 4'd8, 8'h00);

    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
